// File: rtl/cordic_phase_sequencer.sv
// Phase-accumulating sequencer for an iterative CORDIC: issues one angle per sample, waits for done, wraps phase into [-PI, PI).
// Result is held in HOLD until out_ready; no new CORDIC start is issued while the output is stalled.
module cordic_phase_sequencer #(
  parameter int WIDTH       = 16,
  parameter int ANGLE_WIDTH = 32,
  parameter int TIMEOUT     = 31
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          load,
  input  logic signed [ANGLE_WIDTH-1:0] phase_init,
  input  logic signed [ANGLE_WIDTH-1:0] phase_step,
  output logic                          cordic_start,
  output logic signed [ANGLE_WIDTH-1:0] cordic_angle,
  output logic signed [WIDTH-1:0]       cordic_x_start,
  output logic signed [WIDTH-1:0]       cordic_y_start,
  input  logic                          cordic_done,
  input  logic signed [WIDTH-1:0]       cordic_cos,
  input  logic signed [WIDTH-1:0]       cordic_sin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WIDTH-1:0]       out_cos,
  output logic signed [WIDTH-1:0]       out_sin,
  output logic signed [ANGLE_WIDTH-1:0] out_angle,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [15:0]                   sample_count
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic signed [ANGLE_WIDTH:0] PI_EXT     = (ANGLE_WIDTH+1)'(33'sh0_6487ED51);
  localparam logic signed [ANGLE_WIDTH:0] TWO_PI_EXT = (ANGLE_WIDTH+1)'(33'sh0_C90FDAA2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [ANGLE_WIDTH-1:0] phase_q;
  logic signed [ANGLE_WIDTH-1:0] phase_next;
  logic signed [ANGLE_WIDTH:0]   sum_ext;
  logic signed [ANGLE_WIDTH:0]   wrap_ext;
  logic [CNT_W-1:0]              wait_cnt;
  logic                          timeout_hit;
  logic                          accept;

  // Gain-compensated start vector; independent of state and reset.
  assign cordic_x_start = WIDTH'(16'sh26DD);
  assign cordic_y_start = '0;

  assign timeout_hit = (state == WAIT) && !cordic_done && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign accept      = (state == HOLD) && out_ready;

  // Sign-extended add, then a single correction brings the sum back into [-PI, PI).
  always_comb begin
    sum_ext  = {phase_q[ANGLE_WIDTH-1], phase_q} + {phase_step[ANGLE_WIDTH-1], phase_step};
    wrap_ext = sum_ext;
    if (sum_ext >= PI_EXT) begin
      wrap_ext = sum_ext - TWO_PI_EXT;
    end else if (sum_ext < -PI_EXT) begin
      wrap_ext = sum_ext + TWO_PI_EXT;
    end
  end

  assign phase_next = ANGLE_WIDTH'(wrap_ext);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!load && enable) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cordic_done) begin
          state_nxt = HOLD;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = enable ? ISSUE : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    cordic_start = (state == ISSUE);
    busy         = (state != IDLE);
    out_valid    = (state == HOLD);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= '0;
      cordic_angle <= '0;
      wait_cnt     <= '0;
      out_cos      <= '0;
      out_sin      <= '0;
      out_angle    <= '0;
      timeout_err  <= 1'b0;
      sample_count <= '0;
    end else begin
      if (state == IDLE && load) begin
        phase_q     <= phase_init;
        timeout_err <= 1'b0;
      end

      // Angle is latched on entry to ISSUE and held through WAIT.
      if (state_nxt == ISSUE) begin
        cordic_angle <= phase_q;
      end

      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (state == WAIT && cordic_done) begin
        out_cos   <= cordic_cos;
        out_sin   <= cordic_sin;
        out_angle <= cordic_angle;
        phase_q   <= phase_next;
      end

      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end

      if (accept) begin
        sample_count <= sample_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Directed bench for cordic_phase_sequencer with a behavioural CORDIC responder and result scoreboard.
module tb_cordic_phase_sequencer;

  localparam int DLY = 18;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        load;
  logic [31:0] phase_init;
  logic [31:0] phase_step;
  logic        cordic_start;
  logic [31:0] cordic_angle;
  logic [15:0] cordic_x_start;
  logic [15:0] cordic_y_start;
  logic        cordic_done;
  logic [15:0] cordic_cos;
  logic [15:0] cordic_sin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cos;
  logic [15:0] out_sin;
  logic [31:0] out_angle;
  logic        busy;
  logic        timeout_err;
  logic [15:0] sample_count;

  cordic_phase_sequencer #(.WIDTH(16), .ANGLE_WIDTH(32), .TIMEOUT(31)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .load           (load),
    .phase_init     (phase_init),
    .phase_step     (phase_step),
    .cordic_start   (cordic_start),
    .cordic_angle   (cordic_angle),
    .cordic_x_start (cordic_x_start),
    .cordic_y_start (cordic_y_start),
    .cordic_done    (cordic_done),
    .cordic_cos     (cordic_cos),
    .cordic_sin     (cordic_sin),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_cos        (out_cos),
    .out_sin        (out_sin),
    .out_angle      (out_angle),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .sample_count   (sample_count)
  );

  typedef struct {
    logic [15:0] c;
    logic [15:0] s;
    logic [31:0] a;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] angle_log[$];

  int          checks = 0;
  int          failures = 0;
  int          start_cnt = 0;
  int          timer = 0;
  int          exp_samples = 0;
  logic [15:0] seq = 16'd0;
  logic [31:0] ref_phase = 32'd0;
  logic        model_en = 1'b1;
  logic        force_done = 1'b0;
  logic        bp = 1'b0;
  int          sc0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wrap(input logic [31:0] p, input logic [31:0] st);
    logic signed [32:0] s;
    s = $signed({p[31], p}) + $signed({st[31], st});
    if (s >= 33'sh0_6487ED51) s = s - 33'sh0_C90FDAA2;
    else if (s < -33'sh0_6487ED51) s = s + 33'sh0_C90FDAA2;
    return s[31:0];
  endfunction

  // One cycle: CORDIC responder, start monitor, then output consumer/scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clock);
    cordic_done = 1'b0;
    if (force_done) begin
      cordic_done = 1'b1;
      force_done  = 1'b0;
    end else if (timer != 0) begin
      timer--;
      if (timer == 0) begin
        cordic_done = 1'b1;
        cordic_cos  = 16'h1000 + seq;
        cordic_sin  = 16'hF000 - seq;
        seq++;
        e.c = cordic_cos;
        e.s = cordic_sin;
        e.a = ref_phase;
        sb.push_back(e);
        ref_phase = wrap(ref_phase, phase_step);
      end
    end
    if (cordic_start) begin
      start_cnt++;
      angle_log.push_back(cordic_angle);
      check("start_angle", cordic_angle, ref_phase);
      if (model_en) timer = DLY;
    end
    out_ready = !bp;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_cos", 32'(out_cos), 32'(e.c));
        check("out_sin", 32'(out_sin), 32'(e.s));
        check("out_angle", out_angle, e.a);
        exp_samples++;
      end
    end
  endtask

  task automatic wait_starts(input int n, input int max);
    for (int i = 0; i < max && start_cnt < n; i++) step();
    check("wait_starts", start_cnt, n);
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && busy; i++) step();
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] p);
    phase_init = p;
    load       = 1'b1;
    ref_phase  = p;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b1;
    enable      = 1'b0;
    load        = 1'b0;
    phase_init  = 32'd0;
    phase_step  = 32'd0;
    cordic_done = 1'b0;
    cordic_cos  = 16'd0;
    cordic_sin  = 16'd0;
    out_ready   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(cordic_start), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_angle", cordic_angle, 32'd0);
    check("rst_count", 32'(sample_count), 32'd0);
    check("rst_x_start", 32'(cordic_x_start), 32'h26DD);
    check("rst_y_start", 32'(cordic_y_start), 32'h0000);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Positive wrap; a load while busy must be ignored.
    do_load(32'h0000_0000);
    phase_step = 32'h3243F6A9;
    enable     = 1'b1;
    start_cnt  = 0;
    angle_log.delete();
    wait_starts(2, 200);
    phase_init = 32'h1234_5678;
    load       = 1'b1;
    step();
    load = 1'b0;
    wait_starts(4, 200);
    enable = 1'b0;
    drain(100);
    check("posw_a0", angle_log[0], 32'h0000_0000);
    check("posw_a1", angle_log[1], 32'h3243F6A9);
    check("posw_a2", angle_log[2], 32'h9B7812B0);
    check("posw_a3", angle_log[3], 32'hCDBC0959);
    check("posw_count", 32'(sample_count), 32'(exp_samples));
    check("posw_count_abs", 32'(sample_count), 32'd4);
    check("posw_sb_empty", sb.size(), 0);

    // Negative wrap; load takes priority over enable in IDLE.
    phase_step = 32'hFFFF_FFFF;
    enable     = 1'b1;
    do_load(32'h9B7812AF);
    check("load_prio_busy", 32'(busy), 32'd0);
    start_cnt = 0;
    angle_log.delete();
    wait_starts(2, 200);
    enable = 1'b0;
    drain(100);
    check("negw_a0", angle_log[0], 32'h9B7812AF);
    check("negw_a1", angle_log[1], 32'h6487ED50);

    // Backpressure in HOLD.
    phase_step = 32'h0100_0000;
    bp         = 1'b1;
    enable     = 1'b1;
    for (int i = 0; i < 100 && !out_valid; i++) step();
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    sc0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_no_start", 32'(cordic_start), 32'd0);
      check("bp_cos_stable", 32'(out_cos), 32'(sb[0].c));
      check("bp_angle_stable", out_angle, sb[0].a);
    end
    check("bp_start_cnt", start_cnt, sc0);
    bp = 1'b0;
    step();
    step();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_start", 32'(cordic_start), 32'd1);
    check("bp_release_count", 32'(sample_count), 32'(exp_samples));
    enable = 1'b0;
    drain(100);

    // Timeout: CORDIC never answers.
    model_en = 1'b0;
    do_load(32'h1111_1111);
    enable    = 1'b1;
    start_cnt = 0;
    wait_starts(1, 10);
    enable = 1'b0;
    repeat (31) step();
    check("to_busy_before", 32'(busy), 32'd1);
    check("to_err_before", 32'(timeout_err), 32'd0);
    step();
    check("to_busy_after", 32'(busy), 32'd0);
    check("to_err_after", 32'(timeout_err), 32'd1);
    check("to_valid", 32'(out_valid), 32'd0);
    repeat (3) step();
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    model_en = 1'b1;
    enable   = 1'b1;
    wait_starts(2, 10);
    check("to_phase_kept", cordic_angle, 32'h1111_1111);
    enable = 1'b0;
    drain(100);
    check("to_err_after_op", 32'(timeout_err), 32'd1);
    do_load(32'h0000_0000);
    check("to_err_cleared", 32'(timeout_err), 32'd0);

    // Reset mid-WAIT, then a late done while IDLE.
    enable    = 1'b1;
    start_cnt = 0;
    wait_starts(1, 10);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_start", 32'(cordic_start), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_angle", cordic_angle, 32'd0);
    check("mid_rst_out_cos", 32'(out_cos), 32'd0);
    check("mid_rst_out_angle", out_angle, 32'd0);
    check("mid_rst_count", 32'(sample_count), 32'd0);
    check("mid_rst_x_start", 32'(cordic_x_start), 32'h26DD);
    enable      = 1'b0;
    timer       = 0;
    ref_phase   = 32'd0;
    exp_samples = 0;
    sb.delete();
    step();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    cordic_cos = 16'h5555;
    cordic_sin = 16'hAAAA;
    force_done = 1'b1;
    step();
    repeat (3) step();
    check("late_done_valid", 32'(out_valid), 32'd0);
    check("late_done_count", 32'(sample_count), 32'd0);
    check("late_done_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
